// File: rtl/fir_capture_buffer.sv
// Triggered capture of a DEPTH-sample window of FIR output into RAM, with a
// registered random-access read port and running signed min/max.
//   state   | meaning
//   IDLE    | waiting for arm
//   ARMED   | watching for rising crossing of TRIG_LEVEL or force_trig
//   CAPTURE | writing valid samples at wr_count
//   DONE    | window complete, RAM and min/max held until re-arm
module fir_capture_buffer #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 200,
  parameter int ADDR_W     = 8,
  parameter int TRIG_LEVEL = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  input  logic                     arm,
  input  logic                     force_trig,
  input  logic        [ADDR_W-1:0] rd_addr,
  output logic signed [DATA_W-1:0] rd_data,
  output logic                     busy,
  output logic                     done,
  output logic        [ADDR_W:0]   wr_count,
  output logic signed [DATA_W-1:0] max_val,
  output logic signed [DATA_W-1:0] min_val
);

  localparam logic signed [DATA_W-1:0] TRIG     = DATA_W'(TRIG_LEVEL);
  localparam logic        [ADDR_W:0]   LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
  localparam logic        [ADDR_W:0]   ONE      = (ADDR_W+1)'(1);
  localparam logic        [ADDR_W-1:0] RD_LIMIT = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  state_t state;

  logic signed [DATA_W-1:0] mem [DEPTH];
  logic signed [DATA_W-1:0] prev_data;
  logic                     prev_valid;
  logic                     force_pend;
  logic                     crossing;
  logic                     trig;
  logic                     wr_en;
  logic        [ADDR_W-1:0] wr_addr;

  // A force without a valid sample is remembered so the next valid sample starts the window.
  always_comb begin
    crossing = prev_valid && (prev_data < TRIG) && (in_data >= TRIG);
    trig     = in_valid && (crossing || force_trig || force_pend);
    wr_en    = ((state == ARMED) && trig) || ((state == CAPTURE) && in_valid);
    wr_addr  = (state == CAPTURE) ? wr_count[ADDR_W-1:0] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      wr_count   <= '0;
      max_val    <= '0;
      min_val    <= '0;
      prev_data  <= '0;
      prev_valid <= 1'b0;
      force_pend <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (arm) begin
            state      <= ARMED;
            busy       <= 1'b1;
            done       <= 1'b0;
            wr_count   <= '0;
            max_val    <= '0;
            min_val    <= '0;
            prev_valid <= 1'b0;
            force_pend <= 1'b0;
          end
        end
        ARMED: begin
          if (trig) begin
            wr_count   <= ONE;
            max_val    <= in_data;
            min_val    <= in_data;
            force_pend <= 1'b0;
            if (LAST_IDX == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= CAPTURE;
            end
          end else begin
            if (force_trig) force_pend <= 1'b1;
            if (in_valid) begin
              prev_data  <= in_data;
              prev_valid <= 1'b1;
            end
          end
        end
        CAPTURE: begin
          if (in_valid) begin
            wr_count <= wr_count + ONE;
            if (in_data > max_val) max_val <= in_data;
            if (in_data < min_val) min_val <= in_data;
            if (wr_count == LAST_IDX) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Non-blocking write and read give read-before-write on a shared address.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= (rd_addr < RD_LIMIT) ? mem[rd_addr] : '0;
  end

endmodule

// File: tb/tb_fir_capture_buffer.sv
// Bench for fir_capture_buffer: directed scenarios with random data, checked
// against a window model built from the accepted-sample stream since arm.
module tb_fir_capture_buffer;
  localparam int DATA_W = 32, DEPTH = 200, ADDR_W = 8, TRIG_LEVEL = 0;

  logic                     clk = 1'b0;
  logic                     rst;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_valid, arm, force_trig;
  logic        [ADDR_W-1:0] rd_addr;
  logic signed [DATA_W-1:0] rd_data, max_val, min_val;
  logic                     busy, done;
  logic        [ADDR_W:0]   wr_count;

  always #5 clk = ~clk;

  fir_capture_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TRIG_LEVEL(TRIG_LEVEL)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .arm(arm),
    .force_trig(force_trig), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
    .done(done), .wr_count(wr_count), .max_val(max_val), .min_val(min_val)
  );

  int checks = 0, errors = 0;
  logic signed [31:0] stream[$];
  int force_idx = -1;
  bit tracking = 1'b0;
  logic signed [31:0] old_win [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  // Index in the accepted stream of the triggering sample, or -1.
  function automatic int trig_idx();
    int k = -1;
    for (int i = 1; i < stream.size(); i++)
      if (stream[i-1] < TRIG_LEVEL && stream[i] >= TRIG_LEVEL) begin
        k = i;
        break;
      end
    if (force_idx >= 0 && force_idx < stream.size() && (k < 0 || force_idx < k)) k = force_idx;
    return k;
  endfunction

  function automatic int cap_count();
    int k, n;
    k = trig_idx();
    if (!tracking || k < 0) return 0;
    n = stream.size() - k;
    return (n > DEPTH) ? DEPTH : n;
  endfunction

  function automatic bit complete();
    return tracking && (cap_count() == DEPTH);
  endfunction

  function automatic logic signed [31:0] ref_ext(input bit want_max);
    int k, n;
    logic signed [31:0] m;
    k = trig_idx();
    n = cap_count();
    if (n == 0) return '0;
    m = stream[k];
    for (int i = 1; i < n; i++)
      if (want_max ? (stream[k+i] > m) : (stream[k+i] < m)) m = stream[k+i];
    return m;
  endfunction

  function automatic logic signed [31:0] sine(input int n);
    real r;
    r = 1000.0 * $sin(2.0 * 3.14159265358979 * real'(n % 200) / 200.0);
    return 32'(int'(r));
  endfunction

  // One clock cycle: drive inputs, advance the model, check status outputs after the edge.
  task automatic cyc(input bit v, input logic signed [31:0] d, input bit a, input bit f);
    in_valid = v; in_data = d; arm = a; force_trig = f;
    if (a && (!tracking || complete())) begin
      tracking = 1'b1;
      stream.delete();
      force_idx = -1;
    end else if (tracking && !complete()) begin
      if (f && force_idx < 0) force_idx = stream.size();
      if (v) stream.push_back(d);
    end
    @(posedge clk);
    #1;
    chk("wr_count", 32'(wr_count), 32'(cap_count()));
    chk("busy", 32'(busy), 32'(tracking && cap_count() < DEPTH));
    chk("done", 32'(done), 32'(tracking && cap_count() == DEPTH));
    chk("max_val", max_val, ref_ext(1'b1));
    chk("min_val", min_val, ref_ext(1'b0));
  endtask

  task automatic readback(input string tag);
    int k;
    k = trig_idx();
    for (int a = 0; a < 256; a++) begin
      rd_addr = 8'(a);
      cyc(1'b0, 0, 1'b0, 1'b0);
      if (a < DEPTH) begin
        chk(tag, rd_data, stream[k+a]);
        old_win[a] = stream[k+a];
      end else begin
        chk(tag, rd_data, 0);
      end
    end
  endtask

  initial begin
    int n, base, wa;
    rst = 1'b1; in_data = '0; in_valid = 1'b0; arm = 1'b0; force_trig = 1'b0; rd_addr = '0;
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wr_count", 32'(wr_count), 0);
    chk("rst_max", max_val, 0);
    chk("rst_min", min_val, 0);
    chk("rst_rd_data", rd_data, 0);
    @(negedge clk);
    rst = 1'b0;

    // force and samples while idle do nothing
    cyc(1'b1, 7, 1'b0, 1'b1);
    cyc(1'b1, -7, 1'b0, 1'b1);

    // sine window, level-crossing trigger
    n = $urandom_range(0, 199);
    cyc(1'b0, 0, 1'b1, 1'b0);
    for (int c = 0; c < 700 && !complete(); c++) begin
      cyc(1'b1, sine(n), 1'b0, 1'b0);
      n++;
    end
    chk("s1_done", 32'(done), 1);
    chk("s1_max", max_val, 1000);
    chk("s1_min", min_val, -1000);
    rd_addr = 8'd0;
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("s1_ram0_nonneg", 32'(rd_data >= 0), 1);
    rd_addr = 8'd199;
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("s1_ram199_neg", 32'(rd_data < 0), 1);
    rd_addr = 8'd250;
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("s1_rd_250", rd_data, 0);
    readback("s1_rd");

    // constant 5, forced trigger with a valid sample
    cyc(1'b1, 5, 1'b1, 1'b0);
    repeat ($urandom_range(1, 5)) cyc(1'b1, 5, 1'b0, 1'b0);
    cyc(1'b1, 5, 1'b0, 1'b1);
    for (int c = 0; c < 300 && !complete(); c++) cyc(1'b1, 5, 1'b0, 1'b0);
    chk("s2_done", 32'(done), 1);
    chk("s2_max", max_val, 5);
    chk("s2_min", min_val, 5);
    readback("s2_rd");

    // sparse valid, force on an invalid cycle
    cyc(1'b0, 0, 1'b1, 1'b0);
    for (int c = 0; c < 1000 && !complete(); c++)
      cyc(c % 3 == 0, $urandom, 1'b0, c == 1);
    chk("s3_done", 32'(done), 1);
    readback("s3_rd");

    // reset mid-capture
    cyc(1'b0, 0, 1'b1, 1'b0);
    for (int c = 0; c < 200 && cap_count() < 57; c++)
      cyc(1'b1, $urandom, 1'b0, c == 2);
    chk("s5_count57", 32'(wr_count), 57);
    rst = 1'b1;
    #1;
    chk("s5_async_busy", 32'(busy), 0);
    chk("s5_async_done", 32'(done), 0);
    chk("s5_async_wr_count", 32'(wr_count), 0);
    tracking = 1'b0;
    in_valid = 1'b0; arm = 1'b0; force_trig = 1'b0;
    @(posedge clk);
    #1;
    chk("s5_edge_busy", 32'(busy), 0);
    chk("s5_edge_done", 32'(done), 0);
    chk("s5_edge_wr_count", 32'(wr_count), 0);
    rst = 1'b0;
    cyc(1'b1, -3, 1'b0, 1'b0);
    cyc(1'b1, 4, 1'b0, 1'b1);
    cyc(1'b0, 0, 1'b1, 1'b0);
    for (int c = 0; c < 300 && !complete(); c++)
      cyc(1'b1, $urandom, 1'b0, c == 1);
    chk("s5_fresh_done", 32'(done), 1);
    readback("s5_rd");

    // re-arm from DONE with ramp; read-before-write and ignored arm during capture
    base = -int'($urandom_range(1, 20));
    cyc(1'b1, 0, 1'b1, 1'b0);
    chk("s6_rearm_done", 32'(done), 0);
    chk("s6_rearm_wr_count", 32'(wr_count), 0);
    for (int c = 0; c < 400 && !complete(); c++) begin
      wa = cap_count();
      rd_addr = 8'(wa);
      cyc(1'b1, base + c, cap_count() == 100, 1'b0);
      chk("s6_read_before_write", rd_data, old_win[wa]);
    end
    chk("s6_done", 32'(done), 1);
    chk("s6_max", max_val, DEPTH - 1);
    chk("s6_min", min_val, 0);
    readback("s6_rd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
